// File: rtl/consmax_opack.sv
// consmax_opack
//   Output packer and elastic buffer for the ConSmax stage. Elements arriving on
//   idata/idata_valid cannot be stalled. They are packed PACK_NUM to a word, and
//   the final word of each row is zero-padded. Packed words are held in a small
//   show-ahead FIFO and delivered to the consumer over a valid/ready handshake.
//
// Ports
//   clk, rstn      : clock (rising edge), asynchronous active-low reset
//   cfg_row_len    : elements per row (0 behaves as 1), latched at row start
//   idata          : element from ConSmax (two's complement)
//   idata_valid    : element strobe, no backpressure
//   odata          : packed word at FIFO head, lane k at [k*ODATA_BIT +: ODATA_BIT]
//   odata_valid    : FIFO head valid
//   odata_last     : head word closes a row
//   odata_ready    : consumer accepts the head word
//   err_overflow   : sticky, a completed word was dropped because the FIFO was full
//   row_sum        : signed sum of the last completed row   (CONSMAX_OPACK_SUM_EN only)
//   row_sum_valid  : one-cycle pulse when row_sum updates  (CONSMAX_OPACK_SUM_EN only)
//
// Optional feature macro: CONSMAX_OPACK_SUM_EN (per-row signed accumulator).

module consmax_opack #(
  parameter int unsigned ODATA_BIT  = 8,
  parameter int unsigned CDATA_BIT  = 8,
  parameter int unsigned PACK_NUM   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [CDATA_BIT-1:0]          cfg_row_len,
  input  logic [ODATA_BIT-1:0]          idata,
  input  logic                          idata_valid,
  output logic [PACK_NUM*ODATA_BIT-1:0] odata,
  output logic                          odata_valid,
  output logic                          odata_last,
  input  logic                          odata_ready,
  output logic                          err_overflow
`ifdef CONSMAX_OPACK_SUM_EN
  ,
  output logic [ODATA_BIT+CDATA_BIT-1:0] row_sum,
  output logic                           row_sum_valid
`endif
);

  localparam int unsigned LANE_W = $clog2(PACK_NUM);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned WORD_W = PACK_NUM * ODATA_BIT;

  // ---------------------------------------------------------------------------
  // Packing datapath
  // ---------------------------------------------------------------------------
  logic [CDATA_BIT-1:0] r_elem_cnt;
  logic [CDATA_BIT-1:0] r_row_len;
  logic [LANE_W-1:0]    r_lane_cnt;
  logic [WORD_W-1:0]    r_pack;

  logic [CDATA_BIT-1:0] w_cfg_len;
  logic [CDATA_BIT-1:0] w_row_len;
  logic                 w_row_end;
  logic                 w_word_done;
  logic [WORD_W-1:0]    w_push_word;
  logic [WORD_W-1:0]    w_pack_nxt;

  // A zero length would never produce a row end, so it is folded to 1.
  assign w_cfg_len = (cfg_row_len == '0) ? CDATA_BIT'(1) : cfg_row_len;

  // At row start the live configuration applies; mid-row the latched copy does.
  assign w_row_len = (r_elem_cnt == '0) ? w_cfg_len : r_row_len;

  assign w_row_end   = idata_valid && (r_elem_cnt == (w_row_len - CDATA_BIT'(1)));
  assign w_word_done = idata_valid &&
                       ((r_lane_cnt == LANE_W'(PACK_NUM - 1)) || w_row_end);

  // Completed word: stored lanes below the current one, the incoming element
  // in the current lane, zeros above it.
  always_comb begin
    w_push_word = '0;
    w_pack_nxt  = r_pack;
    for (int k = 0; k < int'(PACK_NUM); k++) begin
      if (k < int'(r_lane_cnt)) begin
        w_push_word[k*ODATA_BIT +: ODATA_BIT] = r_pack[k*ODATA_BIT +: ODATA_BIT];
      end else if (k == int'(r_lane_cnt)) begin
        w_push_word[k*ODATA_BIT +: ODATA_BIT] = idata;
        w_pack_nxt[k*ODATA_BIT +: ODATA_BIT]  = idata;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_elem_cnt <= '0;
      r_row_len  <= '0;
      r_lane_cnt <= '0;
      r_pack     <= '0;
    end else if (idata_valid) begin
      if (r_elem_cnt == '0) begin
        r_row_len <= w_cfg_len;
      end
      r_elem_cnt <= w_row_end ? '0 : r_elem_cnt + CDATA_BIT'(1);
      if (w_word_done) begin
        r_pack     <= '0;
        r_lane_cnt <= '0;
      end else begin
        r_pack     <= w_pack_nxt;
        r_lane_cnt <= r_lane_cnt + LANE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead FIFO of {last, word}
  // ---------------------------------------------------------------------------
  logic [WORD_W:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_err;

  logic w_full;
  logic w_pop;
  logic w_push_ok;
  logic w_drop;

  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = odata_valid && odata_ready;
  // A pop frees the head slot in the same edge, so a full FIFO still accepts.
  assign w_push_ok = w_word_done && (!w_full || w_pop);
  assign w_drop    = w_word_done && w_full && !w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= {w_row_end, w_push_word};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      unique case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_err <= 1'b1;
      end
    end
  end

  // Outputs derive only from registered FIFO state; zero when empty.
  assign odata_valid  = (r_count != '0);
  assign odata        = odata_valid ? r_mem[r_rptr][WORD_W-1:0] : '0;
  assign odata_last   = odata_valid ? r_mem[r_rptr][WORD_W]     : 1'b0;
  assign err_overflow = r_err;

`ifdef CONSMAX_OPACK_SUM_EN
  // ---------------------------------------------------------------------------
  // Per-row signed accumulator, independent of FIFO state
  // ---------------------------------------------------------------------------
  localparam int unsigned SUM_W = ODATA_BIT + CDATA_BIT;

  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] r_row_sum;
  logic             r_row_sum_valid;
  logic [SUM_W-1:0] w_idata_sx;
  logic [SUM_W-1:0] w_sum;

  assign w_idata_sx = {{CDATA_BIT{idata[ODATA_BIT-1]}}, idata};
  assign w_sum      = r_acc + w_idata_sx;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc           <= '0;
      r_row_sum       <= '0;
      r_row_sum_valid <= 1'b0;
    end else begin
      r_row_sum_valid <= 1'b0;
      if (w_row_end) begin
        r_row_sum       <= w_sum;
        r_row_sum_valid <= 1'b1;
        r_acc           <= '0;
      end else if (idata_valid) begin
        r_acc <= w_sum;
      end
    end
  end

  assign row_sum       = r_row_sum;
  assign row_sum_valid = r_row_sum_valid;
`endif

endmodule

// File: doc/consmax_opack.md
# consmax_opack

Output packer and elastic buffer placed directly downstream of the ConSmax stage. Consumes the per-element integer stream (`odata`/`odata_valid`), which cannot be stalled. Packs `PACK_NUM` consecutive elements into one wide word, zero-padding the final word of each row. Buffers packed words in a small FIFO and hands them to the consumer over a valid/ready interface, flagging any loss caused by downstream backpressure.

## Interface
Parameters:
- `ODATA_BIT`, 8, width of one input element (ConSmax output integer)
- `CDATA_BIT`, 8, width of configuration data
- `PACK_NUM`, 4, elements per output word (power of 2, ≥2)
- `FIFO_DEPTH`, 4, output FIFO depth in words (power of 2, ≥2)

Ports:
- `clk` input 1: single clock, rising edge
- `rstn` input 1: asynchronous active-low reset
- `cfg_row_len` input CDATA_BIT: elements per row; 0 is treated as 1
- `idata` input ODATA_BIT: element from ConSmax (two's complement)
- `idata_valid` input 1: element valid; no backpressure possible
- `odata` output PACK_NUM*ODATA_BIT: packed word, lane k at bits [k*ODATA_BIT +: ODATA_BIT]
- `odata_valid` output 1: FIFO head valid
- `odata_last` output 1: head word is the final word of a row
- `odata_ready` input 1: consumer accepts the head word
- `err_overflow` output 1: sticky; a word was dropped
- `row_sum` output ODATA_BIT+CDATA_BIT: only with `CONSMAX_OPACK_SUM_EN`
- `row_sum_valid` output 1: only with `CONSMAX_OPACK_SUM_EN`

## Operation
- Element counter `elem_cnt` (CDATA_BIT bits) counts elements within the row. Lane counter `lane_cnt` (log2 PACK_NUM bits) counts elements within the word.
- `cfg_row_len` is latched into `row_len_q` when an element is accepted with `elem_cnt==0`. It is ignored mid-row.
- Accepted element (`idata_valid`=1): written to lane `lane_cnt` of the pack register.
  - Row-end element: `elem_cnt == row_len_q-1`, or the first element when the latched length is 1.
  - Word complete when `lane_cnt==PACK_NUM-1` or the element is row-end.
- On word complete, the push word is formed combinationally from the pack register plus the current element. Lanes above the current lane are forced to 0. `last` = row-end. The push happens on the same clock edge.
  - After push: pack register cleared, `lane_cnt`←0.
  - Row-end: `elem_cnt`←0; otherwise `elem_cnt`+1.
- FIFO: show-ahead, stores {last, word}, occupancy counter 0..FIFO_DEPTH.
  - Pop when `odata_valid && odata_ready`.
  - Push and pop in the same cycle are allowed at any occupancy, including full. Full with simultaneous pop means the push succeeds.
- Push while full with no pop: the word is dropped, `err_overflow`←1, counters still advance so row alignment is preserved. Cleared only by reset.
- `odata`/`odata_last` are held stable while `odata_valid && !odata_ready`. They are 0 when the FIFO is empty.

## Timing
- Reset values: `odata`=0, `odata_valid`=0, `odata_last`=0, `err_overflow`=0, `row_sum`=0, `row_sum_valid`=0. All counters and FIFO pointers are 0 and the pack register is cleared.
- Latency: word-completing element sampled at edge E → `odata_valid`=1 in the cycle after E, if the FIFO was empty.
- Throughput: one element per cycle sustained. One word per PACK_NUM cycles, or faster when short rows produce partial words.
- Reset mid-row or with the FIFO non-empty: the partial word and all buffered words are discarded. The next element starts a new row at lane 0.
- `odata_valid` depends only on FIFO state, never combinationally on `odata_ready`.

## Configuration
- `CONSMAX_OPACK_SUM_EN` defined:
  - A signed accumulator (ODATA_BIT+CDATA_BIT bits, sign-extended elements) sums each row.
  - On the edge that accepts the row-end element, `row_sum`←final sum including that element, and `row_sum_valid`=1 for exactly one cycle.
  - `row_sum` holds its value until the next row completes. The accumulator restarts at 0.
  - This path is independent of FIFO state and overflow.
- Not defined: ports `row_sum`/`row_sum_valid` and the accumulator are absent. Packing behaviour is identical.

## Test plan
- PACK_NUM=4, cfg_row_len=8, elements 1..8 back-to-back, `odata_ready`=1 → words {4,3,2,1} (last=0) then {8,7,6,5} (last=1), each valid one cycle after its 4th element.
- cfg_row_len=6, elements 1..6 → second word {0,0,6,5} with last=1; the next row starts at lane 0.
- cfg_row_len=1, elements 9,-3 → two words {0,0,0,9} and {0,0,0,0xFD}, both last=1. With SUM_EN: `row_sum`=9 then -3, each pulsing `row_sum_valid`.
- FIFO_DEPTH=4, `odata_ready`=0, 5 complete words pushed → `err_overflow`=1 after the 5th. Then raise ready → the first 4 words are delivered in order and `odata_valid` drops.
- FIFO full and a push coinciding with a pop → no overflow, occupancy stays 4, order preserved.
- Assert `rstn`=0 mid-row with 2 words buffered → all outputs 0 asynchronously. After release, a fresh 4-element row produces a single correct word.
